// File: rtl/sdram_audio_buf_ctrl.sv
// Request generator and pointer manager for the SDRAM burst core.
// A fixed SDRAM region is used as a circular audio sample buffer. The capture FIFO is drained
// into SDRAM with fixed-length write bursts, and the playback FIFO is refilled from SDRAM with
// fixed-length read bursts. Burst data moves directly between the FIFOs and the core.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_enable                  allows new bursts to be issued
//   i_clear                   request to empty the buffer and rewind both pointers
//   i_wr_fifo_usedw           words waiting in the capture FIFO
//   i_rd_fifo_usedw           words held in the playback FIFO
//   o_wr_fifo_rden            capture FIFO read strobe (= core write data request)
//   o_rd_fifo_wren            playback FIFO write strobe (= core read data valid)
//   o_wr_burst_*              write burst request / length / address to the core
//   i_wr_burst_data_req/finish  write burst handshake from the core
//   o_rd_burst_*              read burst request / length / address to the core
//   i_rd_burst_data_valid/finish  read burst handshake from the core
//   o_buf_level               words currently held in SDRAM
//   o_busy                    a burst is outstanding
//   o_wr_stall                a write burst is wanted but the SDRAM buffer is full
module sdram_audio_buf_ctrl #(
    parameter int unsigned APP_ADDR_WIDTH   = 24,
    parameter int unsigned APP_BURST_WIDTH  = 10,
    parameter int unsigned FIFO_USEDW_WIDTH = 11,
    parameter int unsigned BURST_LEN        = 256,
    parameter int unsigned BUF_BASE         = 0,
    parameter int unsigned BUF_WORDS        = 1048576,
    parameter int unsigned RD_LOW_MARK      = 512
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    input  logic                        i_clear,
    input  logic [FIFO_USEDW_WIDTH-1:0] i_wr_fifo_usedw,
    input  logic [FIFO_USEDW_WIDTH-1:0] i_rd_fifo_usedw,
    output logic                        o_wr_fifo_rden,
    output logic                        o_rd_fifo_wren,
    output logic                        o_wr_burst_req,
    output logic [APP_BURST_WIDTH-1:0]  o_wr_burst_len,
    output logic [APP_ADDR_WIDTH-1:0]   o_wr_burst_addr,
    input  logic                        i_wr_burst_data_req,
    input  logic                        i_wr_burst_finish,
    output logic                        o_rd_burst_req,
    output logic [APP_BURST_WIDTH-1:0]  o_rd_burst_len,
    output logic [APP_ADDR_WIDTH-1:0]   o_rd_burst_addr,
    input  logic                        i_rd_burst_data_valid,
    input  logic                        i_rd_burst_finish,
    output logic [APP_ADDR_WIDTH:0]     o_buf_level,
    output logic                        o_busy,
    output logic                        o_wr_stall
);

    localparam logic [APP_BURST_WIDTH-1:0] LenC     = APP_BURST_WIDTH'(BURST_LEN);
    localparam logic [APP_ADDR_WIDTH-1:0]  PtrBase  = APP_ADDR_WIDTH'(BUF_BASE);
    localparam logic [APP_ADDR_WIDTH-1:0]  PtrLast  =
        APP_ADDR_WIDTH'(BUF_BASE + BUF_WORDS - BURST_LEN);
    localparam logic [APP_ADDR_WIDTH-1:0]  PtrStep  = APP_ADDR_WIDTH'(BURST_LEN);
    localparam logic [APP_ADDR_WIDTH:0]    LvlStep  = (APP_ADDR_WIDTH + 1)'(BURST_LEN);
    localparam logic [APP_ADDR_WIDTH:0]    LvlWrMax = (APP_ADDR_WIDTH + 1)'(BUF_WORDS - BURST_LEN);

    typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_e;

    state_e                      r_state;
    logic [APP_ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [APP_ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [APP_ADDR_WIDTH-1:0]   r_wr_burst_addr;
    logic [APP_ADDR_WIDTH-1:0]   r_rd_burst_addr;
    logic [APP_ADDR_WIDTH:0]     r_buf_level;
    logic                        r_wr_req;
    logic                        r_rd_req;
    logic                        r_busy;
    logic                        r_wr_stall;
    logic                        r_clear_pend;
    logic                        r_prio_rd;  // 0: write wins the next contested grant

    logic [31:0] w_wr_used;
    logic [31:0] w_rd_used;
    logic        w_wr_want;
    logic        w_wr_room;
    logic        w_wr_ok;
    logic        w_rd_ok;

    assign w_wr_used = 32'(i_wr_fifo_usedw);
    assign w_rd_used = 32'(i_rd_fifo_usedw);
    assign w_wr_want = i_enable & (w_wr_used >= BURST_LEN);
    assign w_wr_room = (r_buf_level <= LvlWrMax);
    assign w_wr_ok   = w_wr_want & w_wr_room;
    assign w_rd_ok   = i_enable & (w_rd_used <= RD_LOW_MARK) & (r_buf_level >= LvlStep);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StIdle;
            r_wr_ptr        <= PtrBase;
            r_rd_ptr        <= PtrBase;
            r_wr_burst_addr <= PtrBase;
            r_rd_burst_addr <= PtrBase;
            r_buf_level     <= '0;
            r_wr_req        <= 1'b0;
            r_rd_req        <= 1'b0;
            r_busy          <= 1'b0;
            r_wr_stall      <= 1'b0;
            r_clear_pend    <= 1'b0;
            r_prio_rd       <= 1'b0;
        end else begin
            r_wr_stall <= w_wr_want & ~w_wr_room;
            unique case (r_state)
                StIdle: begin
                    if (r_clear_pend) begin
                        r_wr_ptr     <= PtrBase;
                        r_rd_ptr     <= PtrBase;
                        r_buf_level  <= '0;
                        r_clear_pend <= 1'b0;
                    end else if (w_wr_ok && (!w_rd_ok || !r_prio_rd)) begin
                        r_wr_burst_addr <= r_wr_ptr;
                        r_wr_req        <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= StWrBurst;
                        if (w_rd_ok) r_prio_rd <= 1'b1;
                    end else if (w_rd_ok) begin
                        r_rd_burst_addr <= r_rd_ptr;
                        r_rd_req        <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= StRdBurst;
                        if (w_wr_ok) r_prio_rd <= 1'b0;
                    end
                end
                StWrBurst: begin
                    if (i_wr_burst_finish) begin
                        r_wr_req    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_wr_ptr    <= (r_wr_ptr == PtrLast) ? PtrBase : r_wr_ptr + PtrStep;
                        r_buf_level <= r_buf_level + LvlStep;
                        r_state     <= StIdle;
                    end
                end
                StRdBurst: begin
                    if (i_rd_burst_finish) begin
                        r_rd_req    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rd_ptr    <= (r_rd_ptr == PtrLast) ? PtrBase : r_rd_ptr + PtrStep;
                        r_buf_level <= r_buf_level - LvlStep;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Latched in any state; only acted on from idle so an in-flight burst completes.
            if (i_clear) r_clear_pend <= 1'b1;
        end
    end

    assign o_wr_fifo_rden  = i_wr_burst_data_req;
    assign o_rd_fifo_wren  = i_rd_burst_data_valid;
    assign o_wr_burst_req  = r_wr_req;
    assign o_wr_burst_len  = LenC;
    assign o_wr_burst_addr = r_wr_burst_addr;
    assign o_rd_burst_req  = r_rd_req;
    assign o_rd_burst_len  = LenC;
    assign o_rd_burst_addr = r_rd_burst_addr;
    assign o_buf_level     = r_buf_level;
    assign o_busy          = r_busy;
    assign o_wr_stall      = r_wr_stall;

endmodule

// File: tb/tb_sdram_audio_buf_ctrl.sv
// Directed bench for sdram_audio_buf_ctrl with a 1024-word circular region (4 bursts of 256).
module tb_sdram_audio_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [10:0] wr_usedw = '0;
    logic [10:0] rd_usedw = '0;
    logic        wr_fifo_rden;
    logic        rd_fifo_wren;
    logic        wr_req;
    logic [9:0]  wr_len;
    logic [23:0] wr_addr;
    logic        wr_data_req = 1'b0;
    logic        wr_fin = 1'b0;
    logic        rd_req;
    logic [9:0]  rd_len;
    logic [23:0] rd_addr;
    logic        rd_data_valid = 1'b0;
    logic        rd_fin = 1'b0;
    logic [24:0] level;
    logic        busy;
    logic        stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_audio_buf_ctrl #(
        .APP_ADDR_WIDTH  (24),
        .APP_BURST_WIDTH (10),
        .FIFO_USEDW_WIDTH(11),
        .BURST_LEN       (256),
        .BUF_BASE        (0),
        .BUF_WORDS       (1024),
        .RD_LOW_MARK     (512)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_enable             (enable),
        .i_clear              (clear),
        .i_wr_fifo_usedw      (wr_usedw),
        .i_rd_fifo_usedw      (rd_usedw),
        .o_wr_fifo_rden       (wr_fifo_rden),
        .o_rd_fifo_wren       (rd_fifo_wren),
        .o_wr_burst_req       (wr_req),
        .o_wr_burst_len       (wr_len),
        .o_wr_burst_addr      (wr_addr),
        .i_wr_burst_data_req  (wr_data_req),
        .i_wr_burst_finish    (wr_fin),
        .o_rd_burst_req       (rd_req),
        .o_rd_burst_len       (rd_len),
        .o_rd_burst_addr      (rd_addr),
        .i_rd_burst_data_valid(rd_data_valid),
        .i_rd_burst_finish    (rd_fin),
        .o_buf_level          (level),
        .o_busy               (busy),
        .o_wr_stall           (stall)
    );

    // Stimulus helpers only: they drive and wait, callers make the comparisons.
    task automatic wait_grant(output bit got_wr, output bit got_rd);
        int n = 0;
        got_wr = 1'b0;
        got_rd = 1'b0;
        while (!(wr_req || rd_req) && n < 20) begin
            @(negedge clk);
            n++;
        end
        got_wr = wr_req;
        got_rd = rd_req;
    endtask

    task automatic pulse_finish(input bit is_wr);
        if (is_wr) wr_fin = 1'b1;
        else rd_fin = 1'b1;
        @(negedge clk);
        wr_fin = 1'b0;
        rd_fin = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_req, rd_req, busy, stall} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {wr_req, rd_req, busy, stall});
        end
        checks++;
        if (level !== 25'd0 || wr_addr !== 24'd0 || rd_addr !== 24'd0) begin
            errors++;
            $display("FAIL reset_state got lvl=%0d wa=%0d ra=%0d want 0 0 0", level, wr_addr,
                     rd_addr);
        end
        checks++;
        if (wr_len !== 10'd256 || rd_len !== 10'd256) begin
            errors++;
            $display("FAIL burst_len got %0d/%0d want 256/256", wr_len, rd_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        bit gw, gr;
        // Eligible but disabled: nothing may be granted.
        wr_usedw = 11'd300;
        rd_usedw = 11'd1000;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_req !== 1'b0 || rd_req !== 1'b0) begin
            errors++;
            $display("FAIL enable_low got req=%b%b want 00", wr_req, rd_req);
        end
        enable = 1'b1;
        wait_grant(gw, gr);
        checks++;
        if (!gw || gr || wr_addr !== 24'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr1_grant got w=%b r=%b addr=%0d busy=%b want 1 0 0 1", gw, gr,
                     wr_addr, busy);
        end
        wr_usedw = 11'd0;
        // Wrong-type finish must be ignored; request held until its own finish.
        pulse_finish(1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_req !== 1'b1 || level !== 25'd0) begin
            errors++;
            $display("FAIL wr1_hold got req=%b lvl=%0d want 1 0", wr_req, level);
        end
        wr_data_req = 1'b1;
        rd_data_valid = 1'b1;
        #1;
        checks++;
        if (wr_fifo_rden !== 1'b1 || rd_fifo_wren !== 1'b1) begin
            errors++;
            $display("FAIL strobes got %b%b want 11", wr_fifo_rden, rd_fifo_wren);
        end
        wr_data_req = 1'b0;
        rd_data_valid = 1'b0;
        #1;
        checks++;
        if (wr_fifo_rden !== 1'b0 || rd_fifo_wren !== 1'b0) begin
            errors++;
            $display("FAIL strobes_off got %b%b want 00", wr_fifo_rden, rd_fifo_wren);
        end
        @(negedge clk);
        pulse_finish(1'b1);
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || level !== 25'd256) begin
            errors++;
            $display("FAIL wr1_done got req=%b busy=%b lvl=%0d want 0 0 256", wr_req, busy,
                     level);
        end
        // Finish in idle is ignored.
        pulse_finish(1'b1);
        @(negedge clk);
        checks++;
        if (level !== 25'd256) begin
            errors++;
            $display("FAIL idle_finish got lvl=%0d want 256", level);
        end
        wr_usedw = 11'd300;
        wait_grant(gw, gr);
        checks++;
        if (!gw || wr_addr !== 24'd256) begin
            errors++;
            $display("FAIL wr2_addr got w=%b addr=%0d want 1 256", gw, wr_addr);
        end
        wr_usedw = 11'd0;
        pulse_finish(1'b1);
        checks++;
        if (level !== 25'd512) begin
            errors++;
            $display("FAIL wr2_level got %0d want 512", level);
        end
    endtask

    task automatic test_alternate();
        bit gw, gr;
        bit    exp_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int    exp_addr [4] = '{512, 0, 768, 256};
        int    exp_lvl  [4] = '{768, 512, 768, 512};
        wr_usedw = 11'd300;
        rd_usedw = 11'd100;
        for (int i = 0; i < 4; i++) begin
            wait_grant(gw, gr);
            checks++;
            if (gw !== exp_wr[i] || gr === gw) begin
                errors++;
                $display("FAIL alt_grant%0d got w=%b r=%b want w=%b", i, gw, gr, exp_wr[i]);
            end
            checks++;
            if ((gw ? int'(wr_addr) : int'(rd_addr)) != exp_addr[i]) begin
                errors++;
                $display("FAIL alt_addr%0d got %0d want %0d", i,
                         gw ? wr_addr : rd_addr, exp_addr[i]);
            end
            if (i == 3) begin
                wr_usedw = 11'd0;
                rd_usedw = 11'd1000;
            end
            @(negedge clk);
            pulse_finish(gw);
            checks++;
            if (int'(level) != exp_lvl[i] || wr_req || rd_req) begin
                errors++;
                $display("FAIL alt_level%0d got lvl=%0d req=%b%b want %0d 00", i, level,
                         wr_req, rd_req, exp_lvl[i]);
            end
        end
    endtask

    task automatic test_fill_wrap();
        bit gw, gr;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_usedw = 11'd300;
        rd_usedw = 11'd1000;
        for (int i = 0; i < 4; i++) begin
            wait_grant(gw, gr);
            checks++;
            if (!gw || int'(wr_addr) != i * 256) begin
                errors++;
                $display("FAIL fill_addr%0d got w=%b addr=%0d want 1 %0d", i, gw, wr_addr,
                         i * 256);
            end
            pulse_finish(1'b1);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr_req !== 1'b0 || stall !== 1'b1 || level !== 25'd1024) begin
            errors++;
            $display("FAIL full_block got req=%b stall=%b lvl=%0d want 0 1 1024", wr_req,
                     stall, level);
        end
        rd_usedw = 11'd100;
        wait_grant(gw, gr);
        checks++;
        if (!gr || rd_addr !== 24'd0) begin
            errors++;
            $display("FAIL full_read got r=%b addr=%0d want 1 0", gr, rd_addr);
        end
        rd_usedw = 11'd1000;
        pulse_finish(1'b0);
        wait_grant(gw, gr);
        checks++;
        if (!gw || wr_addr !== 24'd0) begin
            errors++;
            $display("FAIL wrap_write got w=%b addr=%0d want 1 0", gw, wr_addr);
        end
        wr_usedw = 11'd0;
        pulse_finish(1'b1);
        checks++;
        if (level !== 25'd1024) begin
            errors++;
            $display("FAIL wrap_level got %0d want 1024", level);
        end
    endtask

    task automatic test_read_drain();
        bit gw, gr;
        int exp_addr [4] = '{256, 512, 768, 0};
        rd_usedw = 11'd100;
        for (int i = 0; i < 4; i++) begin
            wait_grant(gw, gr);
            checks++;
            if (!gr || int'(rd_addr) != exp_addr[i]) begin
                errors++;
                $display("FAIL drain_addr%0d got r=%b addr=%0d want 1 %0d", i, gr, rd_addr,
                         exp_addr[i]);
            end
            pulse_finish(1'b0);
            checks++;
            if (int'(level) != 768 - i * 256) begin
                errors++;
                $display("FAIL drain_level%0d got %0d want %0d", i, level, 768 - i * 256);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rd_req !== 1'b0) begin
            errors++;
            $display("FAIL empty_block got req=%b want 0", rd_req);
        end
    endtask

    task automatic test_clear();
        bit gw, gr;
        rd_usedw = 11'd1000;
        wr_usedw = 11'd300;
        wait_grant(gw, gr);
        checks++;
        if (!gw || wr_addr !== 24'd256) begin
            errors++;
            $display("FAIL clr_wr got w=%b addr=%0d want 1 256", gw, wr_addr);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wr_usedw = 11'd0;
        @(negedge clk);
        checks++;
        if (wr_req !== 1'b1) begin
            errors++;
            $display("FAIL clr_inflight got req=%b want 1", wr_req);
        end
        pulse_finish(1'b1);
        checks++;
        if (level !== 25'd256) begin
            errors++;
            $display("FAIL clr_finish got lvl=%0d want 256", level);
        end
        @(negedge clk);
        checks++;
        if (level !== 25'd0) begin
            errors++;
            $display("FAIL clr_applied got lvl=%0d want 0", level);
        end
        wr_usedw = 11'd300;
        wait_grant(gw, gr);
        checks++;
        if (!gw || wr_addr !== 24'd0) begin
            errors++;
            $display("FAIL clr_next_wr got w=%b addr=%0d want 1 0", gw, wr_addr);
        end
        wr_usedw = 11'd0;
        pulse_finish(1'b1);
        rd_usedw = 11'd100;
        wait_grant(gw, gr);
        checks++;
        if (!gr || rd_addr !== 24'd0) begin
            errors++;
            $display("FAIL clr_next_rd got r=%b addr=%0d want 1 0", gr, rd_addr);
        end
    endtask

    task automatic test_reset_mid_read();
        repeat (2) @(negedge clk);
        checks++;
        if (rd_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got req=%b busy=%b want 1 1", rd_req, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_req !== 1'b0 || wr_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got req=%b%b busy=%b want 00 0", wr_req, rd_req, busy);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (level !== 25'd0 || wr_addr !== 24'd0 || rd_addr !== 24'd0 || rd_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_after got lvl=%0d wa=%0d ra=%0d req=%b want 0 0 0 0", level,
                     wr_addr, rd_addr, rd_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_alternate();
        test_fill_wrap();
        test_read_drain();
        test_clear();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
